// File: rtl/bitty_fetch_pkg.sv
// bitty_fetch_pkg: state encodings and default
// widths shared by the fetch stage.
package bitty_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_EXEC  = 2'd2
  } fs_state_e;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_TIMEOUT = 15;

  localparam logic [7:0] PC_RESET = 8'h00;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts FETCH cycles without ack.
// Ports: clk, rst_n, clear, en -> expired.
module fetch_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fires during the LIMIT-th enabled cycle,
  // so the caller leaves on that edge.
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and imem req/ack fetch FSM.
// Optional fetch timeout under FETCH_TIMEOUT_EN.
// Ports: clk, rst_n, run_en; imem_req/addr/ack/rdata;
//  instr, instr_valid, pc; exec_done, new_pc;
//  retired (count), fetch_err (sticky timeout).
module fetch_unit
  import bitty_fetch_pkg::*;
#(
  parameter int ADDR_W         = FETCH_ADDR_W,
  parameter int INSTR_W        = FETCH_INSTR_W,
  parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               exec_done,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic [15:0]        retired,
  output logic               fetch_err
);

  fs_state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [15:0]        ret_q;
  logic               req_q;
  logic               valid_q;
  logic               err_q;

  logic load_instr;
  logic retire;
  logic set_err;
  logic expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != FS_FETCH),
    .en      (state_q == FS_FETCH),
    .expired (expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    retire     = 1'b0;
    set_err    = 1'b0;
    unique case (1'b1)
      (state_q == FS_IDLE): begin
        if (run_en && !err_q)
          state_d = FS_FETCH;
      end
      (state_q == FS_FETCH): begin
        // ack wins over a same-cycle timeout
        if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = FS_EXEC;
        end else if (expired) begin
          set_err = 1'b1;
          state_d = FS_IDLE;
        end
      end
      (state_q == FS_EXEC): begin
        if (exec_done) begin
          retire  = 1'b1;
          state_d = run_en ? FS_FETCH : FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= ADDR_W'(PC_RESET);
      instr_q <= '0;
      ret_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // req/valid are flops fed by next state
      req_q   <= (state_d == FS_FETCH);
      valid_q <= (state_d == FS_EXEC);
      if (load_instr)
        instr_q <= imem_rdata;
      if (retire) begin
        pc_q  <= new_pc;
        ret_q <= ret_q + 16'd1;
      end
      if (set_err)
        err_q <= 1'b1;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign retired     = ret_q;
  assign fetch_err   = err_q;

endmodule
